// File: rtl/uart_cmd_exec.sv
// uart_cmd_exec
//   Executes commands parsed by the upstream UART receiver. It decodes ASCII-hex
//   address and data fields, performs a write or read on an internal register
//   file, and streams an ASCII response ("OK", eight hex digits, or "ER", each
//   followed by CR LF) to the UART transmitter.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   STATE_W, STATE_R, FAIL     command flags, sampled with OUTPUT_DONE
//   ADDR[15:0], DATA[63:0]     ASCII hex fields (most significant char first)
//   OUTPUT_DONE                one-cycle command strobe
//   TX_DATA, TX_VALID/TX_READY response byte stream handshake
//   BUSY                       command capture through last byte accepted
//   CMD_DROP                   pulse: strobe arrived while busy
//   WR_PULSE, WR_ADDR, WR_DATA register write indication and last write
module uart_cmd_exec #(
   parameter int unsigned REG_DEPTH = 16,
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        STATE_W,
   input  logic        STATE_R,
   input  logic [15:0] ADDR,
   input  logic [63:0] DATA,
   input  logic        FAIL,
   input  logic        OUTPUT_DONE,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   output logic        BUSY,
   output logic        CMD_DROP,
   output logic        WR_PULSE,
   output logic [7:0]  WR_ADDR,
   output logic [31:0] WR_DATA
);

   localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SEND} state_t;

   state_t      r_state;
   logic        r_w, r_r, r_fail;
   logic [15:0] r_addr_c;
   logic [63:0] r_data_c;
   logic [31:0] r_regs [REG_DEPTH];
   logic [7:0]  r_buf [10];
   logic [3:0]  r_len, r_idx;
   logic [7:0]  r_tx_data;
   logic        r_tx_valid, r_busy, r_cmd_drop;
   logic [7:0]  r_wr_addr;
   logic [31:0] r_wr_data;

   logic [4:0]  w_ah, w_al, w_dn;
   logic [7:0]  w_addr;
   logic        w_addr_ok;
   logic [31:0] w_data;
   logic        w_data_ok;
   logic        w_do_write, w_do_read;
   logic [31:0] w_rd_val;

   // {valid, nibble}; only '0'-'9' and 'A'-'F' are accepted
   function automatic logic [4:0] hex_dec(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
      else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
      else                               return '0;
   endfunction

   function automatic logic [7:0] hex_enc(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   always_comb begin
      w_ah      = hex_dec(r_addr_c[15:8]);
      w_al      = hex_dec(r_addr_c[7:0]);
      w_addr    = {w_ah[3:0], w_al[3:0]};
      w_addr_ok = w_ah[4] & w_al[4] & ({1'b0, w_addr} < 9'(REG_DEPTH));
      w_data    = '0;
      w_data_ok = 1'b1;
      w_dn      = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         w_dn             = hex_dec(r_data_c[i*8 +: 8]);
         w_data[i*4 +: 4] = w_dn[3:0];
         w_data_ok        = w_data_ok & w_dn[4];
      end
      // FAIL dominates, then write, then read
      w_do_write = (r_state == S_EXEC) & ~r_fail & r_w & w_addr_ok & w_data_ok;
      w_do_read  = ~r_fail & ~r_w & r_r & w_addr_ok;
      w_rd_val   = r_regs[w_addr[AW-1:0]];
   end

   // Write indication is visible during the EXEC cycle itself, so the pulse and
   // the new address/data are presented combinationally and then held in r_wr_*.
   assign WR_PULSE = w_do_write;
   assign WR_ADDR  = w_do_write ? w_addr : r_wr_addr;
   assign WR_DATA  = w_do_write ? w_data : r_wr_data;
   assign TX_DATA  = r_tx_data;
   assign TX_VALID = r_tx_valid;
   assign BUSY     = r_busy;
   assign CMD_DROP = r_cmd_drop;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= S_IDLE;
         r_w        <= 1'b0;
         r_r        <= 1'b0;
         r_fail     <= 1'b0;
         r_addr_c   <= '0;
         r_data_c   <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_cmd_drop <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         for (int unsigned i = 0; i < REG_DEPTH; i++) r_regs[i] <= RESET_VAL;
         for (int unsigned i = 0; i < 10; i++) r_buf[i] <= '0;
      end else begin
         r_cmd_drop <= OUTPUT_DONE & r_busy;
         case (r_state)
            S_IDLE: begin
               if (OUTPUT_DONE) begin
                  r_w      <= STATE_W;
                  r_r      <= STATE_R;
                  r_fail   <= FAIL;
                  r_addr_c <= ADDR;
                  r_data_c <= DATA;
                  r_busy   <= 1'b1;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_idx      <= '0;
               r_tx_valid <= 1'b1;
               r_state    <= S_SEND;
               if (w_do_write) begin
                  r_regs[w_addr[AW-1:0]] <= w_data;
                  r_wr_addr <= w_addr;
                  r_wr_data <= w_data;
                  r_buf[0]  <= 8'h4F;
                  r_buf[1]  <= 8'h4B;
                  r_buf[2]  <= 8'h0D;
                  r_buf[3]  <= 8'h0A;
                  r_len     <= 4'd4;
                  r_tx_data <= 8'h4F;
               end else if (w_do_read) begin
                  for (int unsigned i = 0; i < 8; i++)
                     r_buf[i] <= hex_enc(w_rd_val[(7-i)*4 +: 4]);
                  r_buf[8]  <= 8'h0D;
                  r_buf[9]  <= 8'h0A;
                  r_len     <= 4'd10;
                  r_tx_data <= hex_enc(w_rd_val[31:28]);
               end else begin
                  r_buf[0]  <= 8'h45;
                  r_buf[1]  <= 8'h52;
                  r_buf[2]  <= 8'h0D;
                  r_buf[3]  <= 8'h0A;
                  r_len     <= 4'd4;
                  r_tx_data <= 8'h45;
               end
            end
            S_SEND: begin
               if (r_tx_valid && TX_READY) begin
                  if (r_idx == r_len - 4'd1) begin
                     r_tx_valid <= 1'b0;
                     r_busy     <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_idx     <= r_idx + 4'd1;
                     r_tx_data <= r_buf[r_idx + 4'd1];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_exec.sv
// Testbench for uart_cmd_exec: a transaction-level model predicts the response
// byte stream, BUSY/TX_VALID timing, write pulses and dropped commands; a
// compare process checks the DUT every cycle, and directed cases pin the model
// with hand-computed literal responses.
module tb_uart_cmd_exec;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] RVAL  = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        STATE_W = 1'b0, STATE_R = 1'b0, FAIL = 1'b0, OUTPUT_DONE = 1'b0;
   logic [15:0] ADDR = '0;
   logic [63:0] DATA = '0;
   logic        TX_READY = 1'b1;
   logic [7:0]  TX_DATA;
   logic        TX_VALID, BUSY, CMD_DROP, WR_PULSE;
   logic [7:0]  WR_ADDR;
   logic [31:0] WR_DATA;

   uart_cmd_exec #(.REG_DEPTH(DEPTH), .RESET_VAL(RVAL)) dut (
      .CLK(CLK), .RST_N(RST_N), .STATE_W(STATE_W), .STATE_R(STATE_R),
      .ADDR(ADDR), .DATA(DATA), .FAIL(FAIL), .OUTPUT_DONE(OUTPUT_DONE),
      .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .BUSY(BUSY), .CMD_DROP(CMD_DROP), .WR_PULSE(WR_PULSE),
      .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   string HX = "0123456789ABCDEF";

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_regs [DEPTH];
   logic [7:0]  q[$];
   logic [7:0]  rx_log[$];
   logic        m_busy = 1'b0, drop_pend = 1'b0;
   logic        p_wr = 1'b0;
   logic [7:0]  p_addr = '0, m_wr_addr = '0;
   logic [31:0] p_data = '0, m_wr_data = '0;
   int          cyc = 0, exec_cyc = -10, wr_pulse_cnt = 0;

   function automatic int hv(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
      return -1;
   endfunction

   task automatic push_err();
      q.push_back(8'h45);
      q.push_back(8'h52);
   endtask

   task automatic model_accept();
      int ah, al, a, v, nib;
      bit aok, dok;
      logic [31:0] d;
      ah  = hv(ADDR[15:8]);
      al  = hv(ADDR[7:0]);
      a   = ah * 16 + al;
      aok = (ah >= 0) && (al >= 0) && (a < int'(DEPTH));
      dok = 1'b1;
      d   = '0;
      for (int i = 0; i < 8; i++) begin
         v = hv(DATA[63-8*i -: 8]);
         if (v < 0) dok = 1'b0;
         else d = {d[27:0], 4'(v)};
      end
      q.delete();
      p_wr     = 1'b0;
      exec_cyc = cyc + 1;
      m_busy   = 1'b1;
      if (FAIL) push_err();
      else if (STATE_W) begin
         if (aok && dok) begin
            m_regs[a] = d;
            p_wr   = 1'b1;
            p_addr = 8'(a);
            p_data = d;
            q.push_back(8'h4F);
            q.push_back(8'h4B);
         end else push_err();
      end else if (STATE_R) begin
         if (aok) begin
            for (int i = 0; i < 8; i++) begin
               nib = int'((m_regs[a] >> (28 - 4*i)) & 32'hF);
               q.push_back(HX[nib]);
            end
         end else push_err();
      end else push_err();
      q.push_back(8'h0D);
      q.push_back(8'h0A);
   endtask

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      logic exp_wr, exp_valid, was_busy;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            for (int i = 0; i < int'(DEPTH); i++) m_regs[i] = RVAL;
            q.delete();
            m_busy = 1'b0; drop_pend = 1'b0; p_wr = 1'b0;
            m_wr_addr = '0; m_wr_data = '0; exec_cyc = -10;
            chk("rst TX_VALID", 64'(TX_VALID), 0);
            chk("rst TX_DATA", 64'(TX_DATA), 0);
            chk("rst BUSY", 64'(BUSY), 0);
            chk("rst CMD_DROP", 64'(CMD_DROP), 0);
            chk("rst WR_PULSE", 64'(WR_PULSE), 0);
            chk("rst WR_ADDR", 64'(WR_ADDR), 0);
            chk("rst WR_DATA", 64'(WR_DATA), 0);
            cyc++;
            continue;
         end
         exp_wr = (cyc == exec_cyc) && p_wr;
         if (exp_wr) begin
            m_wr_addr = p_addr;
            m_wr_data = p_data;
         end
         exp_valid = m_busy && (cyc > exec_cyc);
         chk("BUSY", 64'(BUSY), 64'(m_busy));
         chk("TX_VALID", 64'(TX_VALID), 64'(exp_valid));
         if (exp_valid && TX_VALID && q.size() > 0) chk("TX_DATA", 64'(TX_DATA), 64'(q[0]));
         chk("WR_PULSE", 64'(WR_PULSE), 64'(exp_wr));
         chk("WR_ADDR", 64'(WR_ADDR), 64'(m_wr_addr));
         chk("WR_DATA", 64'(WR_DATA), 64'(m_wr_data));
         chk("CMD_DROP", 64'(CMD_DROP), 64'(drop_pend));
         if (WR_PULSE) wr_pulse_cnt++;
         was_busy  = m_busy;
         drop_pend = OUTPUT_DONE && was_busy;
         if (exp_valid && TX_VALID && TX_READY && q.size() > 0) begin
            rx_log.push_back(TX_DATA);
            void'(q.pop_front());
            if (q.size() == 0) m_busy = 1'b0;
         end
         if (OUTPUT_DONE && !was_busy) model_accept();
         cyc++;
      end
   end

   // ---------------- TX_READY driver ----------------
   int rdy_mode = 0;
   int tcnt = 0;
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         case (rdy_mode)
            0: TX_READY = 1'b1;
            1: begin tcnt++; TX_READY = tcnt[1]; end
            default: TX_READY = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [63:0] s2v(input string s);
      logic [63:0] v = '0;
      for (int i = 0; i < s.len(); i++) v = {v[55:0], s[i]};
      return v;
   endfunction

   task automatic drive(input logic w, input logic r, input logic f,
                        input logic [15:0] a, input logic [63:0] d);
      STATE_W = w; STATE_R = r; FAIL = f; ADDR = a; DATA = d;
      OUTPUT_DONE = 1'b1;
      @(posedge CLK);
      #1;
      OUTPUT_DONE = 1'b0; STATE_W = 1'b0; STATE_R = 1'b0; FAIL = 1'b0;
   endtask

   task automatic send_cmd(input logic w, input logic r, input logic f,
                           input logic [15:0] a, input logic [63:0] d);
      @(posedge CLK);
      #1;
      drive(w, r, f, a, d);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (1) begin
         @(negedge CLK);
         n++;
         if (!BUSY) break;
         if (n >= 400) begin
            chk("wait_idle timeout", 1, 0);
            break;
         end
      end
   endtask

   task automatic check_bytes(input string nm, input int st, input string body);
      for (int i = 0; i < body.len() + 2; i++) begin
         logic [7:0] e;
         e = (i < body.len()) ? body[i] : ((i == body.len()) ? 8'h0D : 8'h0A);
         if (st + i < rx_log.size()) chk({nm, " byte"}, 64'(rx_log[st+i]), 64'(e));
         else chk({nm, " missing byte"}, 0, 64'(e));
      end
   endtask

   task automatic run_cmd(input string nm, input logic w, input logic r, input logic f,
                          input string a, input string d, input string body);
      int st, pc, n;
      st = rx_log.size();
      pc = wr_pulse_cnt;
      send_cmd(w, r, f, s2v(a)[15:0], s2v(d));
      wait_idle(n);
      chk({nm, " len"}, 64'(rx_log.size() - st), 64'(body.len() + 2));
      check_bytes(nm, st, body);
      chk({nm, " wr pulses"}, 64'(wr_pulse_cnt - pc), (body == "OK") ? 1 : 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed and random stimulus ----------------
   initial begin : stim
      int st, n;
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;
      @(negedge CLK);
      chk("post-reset TX_VALID", 64'(TX_VALID), 0);

      // write "03" = DEADBEEF, literal timing
      st = rx_log.size();
      send_cmd(1'b1, 1'b0, 1'b0, s2v("03")[15:0], s2v("DEADBEEF"));
      @(negedge CLK);
      chk("wr T+1 WR_PULSE", 64'(WR_PULSE), 1);
      chk("wr T+1 WR_ADDR", 64'(WR_ADDR), 64'h03);
      chk("wr T+1 WR_DATA", 64'(WR_DATA), 64'hDEADBEEF);
      chk("wr T+1 TX_VALID", 64'(TX_VALID), 0);
      wait_idle(n);
      chk("wr busy low at T+6", 64'(n), 5);
      check_bytes("wr resp", st, "OK");

      run_cmd("rd 03", 1'b0, 1'b1, 1'b0, "03", "00000000", "DEADBEEF");
      run_cmd("rd 07", 1'b0, 1'b1, 1'b0, "07", "00000000", "00000000");

      run_cmd("err fail", 1'b1, 1'b0, 1'b1, "03", "12345678", "ER");
      run_cmd("err 1G", 1'b1, 1'b0, 1'b0, "1G", "12345678", "ER");
      run_cmd("err wr 10", 1'b1, 1'b0, 1'b0, "10", "12345678", "ER");
      run_cmd("err rd 0a", 1'b0, 1'b1, 1'b0, "0a", "00000000", "ER");
      run_cmd("err none", 1'b0, 1'b0, 1'b0, "03", "12345678", "ER");
      run_cmd("err lc data", 1'b1, 1'b0, 1'b0, "04", "1234567f", "ER");
      run_cmd("rd 03 after errs", 1'b0, 1'b1, 1'b0, "03", "00000000", "DEADBEEF");

      // stalled read
      rdy_mode = 1;
      run_cmd("rd 03 stall", 1'b0, 1'b1, 1'b0, "03", "00000000", "DEADBEEF");

      // second strobe during SEND is dropped
      st = rx_log.size();
      send_cmd(1'b1, 1'b0, 1'b0, s2v("05")[15:0], s2v("12345678"));
      send_cmd(1'b1, 1'b0, 1'b0, s2v("05")[15:0], s2v("AAAAAAAA"));
      @(negedge CLK);
      chk("drop CMD_DROP", 64'(CMD_DROP), 1);
      wait_idle(n);
      check_bytes("drop first resp", st, "OK");
      chk("drop len", 64'(rx_log.size() - st), 4);
      rdy_mode = 0;
      run_cmd("rd 05", 1'b0, 1'b1, 1'b0, "05", "00000000", "12345678");

      // strobe on last-byte cycle dropped, next cycle accepted
      st = rx_log.size();
      send_cmd(1'b1, 1'b0, 1'b0, s2v("06")[15:0], s2v("22222222"));
      repeat (4) @(posedge CLK);
      #1;
      drive(1'b1, 1'b0, 1'b0, s2v("06")[15:0], s2v("11111111"));
      chk("edge CMD_DROP", 64'(CMD_DROP), 1);
      chk("edge BUSY", 64'(BUSY), 0);
      drive(1'b0, 1'b1, 1'b0, s2v("06")[15:0], s2v("00000000"));
      wait_idle(n);
      chk("edge len", 64'(rx_log.size() - st), 14);
      check_bytes("edge wr", st, "OK");
      check_bytes("edge rd", st + 4, "22222222");

      // reset in the middle of a read response
      send_cmd(1'b0, 1'b1, 1'b0, s2v("03")[15:0], s2v("00000000"));
      @(posedge CLK);
      @(posedge CLK);
      #3 RST_N = 1'b0;
      #1;
      chk("midrst TX_VALID", 64'(TX_VALID), 0);
      chk("midrst BUSY", 64'(BUSY), 0);
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
      run_cmd("rd 03 after rst", 1'b0, 1'b1, 1'b0, "03", "00000000", "00000000");

      // randomized commands
      for (int k = 0; k < 80; k++) begin
         int t, a;
         logic w, r, f;
         logic [15:0] av;
         logic [63:0] dv;
         t = $urandom_range(0, 9);
         f = (t == 0);
         w = ((t >= 1) && (t <= 4)) || (f && ($urandom_range(0, 1) == 1));
         r = ((t >= 5) && (t <= 8)) || (w && ($urandom_range(0, 1) == 1));
         a = $urandom_range(0, DEPTH + 3);
         av = {HX[a / 16], HX[a % 16]};
         if ($urandom_range(0, 7) == 0) av[7:0] = 8'($urandom_range(0, 255));
         for (int i = 0; i < 8; i++) dv[i*8 +: 8] = HX[$urandom_range(0, 15)];
         if ($urandom_range(0, 9) == 0) dv[8*$urandom_range(0, 7) +: 8] = 8'h61 + 8'($urandom_range(0, 5));
         rdy_mode = $urandom_range(0, 2);
         send_cmd(w, r, f, av, dv);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 6)) @(posedge CLK);
            send_cmd(1'b1, 1'b0, 1'b0, {HX[0], HX[$urandom_range(0, 15)]}, s2v("CAFEF00D"));
         end
         wait_idle(n);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      rdy_mode = 0;
      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
